// File: rtl/cdb_scheduler.sv
// Common data bus scheduler: two result FIFOs (sum/sub and load/store) drained
// onto one registered broadcast bus, one word per cycle, round-robin on contention.
module cdb_scheduler #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 16
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       alu_valid,
  input  logic [WIDTH-1:0]           alu_result,
  output logic                       alu_ready,
  input  logic                       ldsd_valid,
  input  logic [WIDTH-1:0]           ldsd_result,
  output logic                       ldsd_ready,
  output logic [WIDTH-1:0]           cdb,
  output logic                       cdb_valid,
  output logic [$clog2(DEPTH+1)-1:0] alu_count,
  output logic [$clog2(DEPTH+1)-1:0] ldsd_count
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] a_mem [DEPTH];
  logic [WIDTH-1:0] l_mem [DEPTH];
  logic [PW-1:0]    a_wr, a_rd, l_wr, l_rd;
  logic             rr_last;
  logic             a_push, l_push, grant_a, grant_l;
  logic             a_ne, l_ne;
  logic [WIDTH-1:0] word;

  // Ready is held low while reset is asserted, independent of the cleared counts.
  assign alu_ready  = reset && (alu_count != CW'(DEPTH));
  assign ldsd_ready = reset && (ldsd_count != CW'(DEPTH));

  assign a_push = alu_valid && alu_ready;
  assign l_push = ldsd_valid && ldsd_ready;

  assign a_ne = (alu_count != '0);
  assign l_ne = (ldsd_count != '0);

  // rr_last = 1 means load/store won last, so sum/sub wins the next contention.
  assign grant_a = a_ne && (!l_ne || rr_last);
  assign grant_l = l_ne && (!a_ne || !rr_last);

  always_comb begin
    word = '0;
    if (grant_a) begin
      word     = a_mem[a_rd];
      word[10] = 1'b1;
    end else if (grant_l) begin
      word     = l_mem[l_rd];
      word[10] = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (a_push) a_mem[a_wr] <= alu_result;
    if (l_push) l_mem[l_wr] <= ldsd_result;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      a_wr       <= '0;
      a_rd       <= '0;
      l_wr       <= '0;
      l_rd       <= '0;
      alu_count  <= '0;
      ldsd_count <= '0;
      rr_last    <= 1'b1;
      cdb        <= '0;
      cdb_valid  <= 1'b0;
    end else begin
      if (a_push)  a_wr <= a_wr + 1'b1;
      if (grant_a) a_rd <= a_rd + 1'b1;
      if (l_push)  l_wr <= l_wr + 1'b1;
      if (grant_l) l_rd <= l_rd + 1'b1;

      case ({a_push, grant_a})
        2'b10:   alu_count <= alu_count + 1'b1;
        2'b01:   alu_count <= alu_count - 1'b1;
        default: alu_count <= alu_count;
      endcase

      case ({l_push, grant_l})
        2'b10:   ldsd_count <= ldsd_count + 1'b1;
        2'b01:   ldsd_count <= ldsd_count - 1'b1;
        default: ldsd_count <= ldsd_count;
      endcase

      if (grant_a)      rr_last <= 1'b0;
      else if (grant_l) rr_last <= 1'b1;

      // An idle cycle drives zeros so no consumer re-applies an old word.
      cdb       <= word;
      cdb_valid <= grant_a || grant_l;
    end
  end

endmodule

// File: doc/cdb_scheduler.md
# cdb_scheduler

Shares the single common data bus between the two functional units of the Tomasulo core: the sum/subtract ULA and the load/store ULA. Each unit pushes finished results into its own small FIFO through a valid/ready handshake. The scheduler broadcasts at most one result per cycle on a registered `cdb`, granting round-robin when both units have pending results. It sits between the two ULAs and the consumers of the CDB: the bank of registers and the reservation station.

## Interface
- `DEPTH`, 2: entries per source FIFO; power of two, ≥2.
- `WIDTH`, 16: CDB word width. Bit 15/14/13 = R0/R1/R2 write enables, [12:11] = RS slot, [10] = source, [9:0] = data.
- `clock`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `alu_valid`  in  1  sum/sub ULA offers `alu_result`.
- `alu_result`  in  WIDTH  sum/sub result word, CDB format.
- `alu_ready`  out  1  sum/sub FIFO can accept this cycle.
- `ldsd_valid`  in  1  load/store ULA offers `ldsd_result`.
- `ldsd_result`  in  WIDTH  load/store result word, CDB format.
- `ldsd_ready`  out  1  load/store FIFO can accept this cycle.
- `cdb`  out  WIDTH  broadcast word, registered.
- `cdb_valid`  out  1  `cdb` carries a result this cycle.
- `alu_count`, `ldsd_count`  out  $clog2(DEPTH+1)  FIFO occupancy.

## Operation
- Two independent FIFOs, A (sum/sub) and L (load/store), each DEPTH deep, with wrap-around read and write pointers and an occupancy counter.
- Push: a word is accepted at the rising edge where `x_valid && x_ready`. `x_ready = (x_count != DEPTH)`. Ready does not look ahead to a same-cycle pop.
- Arbitration, combinational on the FIFO heads each cycle:
  - Neither FIFO empty: grant the source not granted last (`rr_last`).
  - Only one FIFO non-empty: grant it. `rr_last` is still updated to that source.
  - Both empty: no grant. `rr_last` is unchanged.
- On a grant, the head is popped at the edge. `cdb` is loaded with the head word with bit 10 overwritten: 1 for source A, 0 for source L. `cdb_valid` is set to 1.
- No grant: `cdb` is loaded with all zeros and `cdb_valid` with 0. The bus must never hold a stale word, or the register bank re-writes it.
- Push and pop on the same FIFO in the same cycle: count is unchanged and both pointers advance.
- Push on a full FIFO cannot occur because ready is low. `x_valid` while not ready is ignored; the word is not stored.
- Counters are `$clog2(DEPTH+1)` bits. Pointers are `$clog2(DEPTH)` bits and wrap naturally.
- State: `rr_last` is 1 bit, 0 = A granted last. After reset it is set to 1, so A wins the first contention.

## Timing
- Reset (`reset`=0, asynchronous), effective immediately:
  - `cdb`=0, `cdb_valid`=0.
  - Counts and pointers = 0.
  - `rr_last`=1.
  - `alu_ready`=`ldsd_ready`=0 while reset is asserted; both go to 1 in the first cycle after release.
- Reset mid-operation discards every queued word. No partial broadcast may appear.
- Latency: a word accepted at edge k into an empty, uncontended FIFO drives `cdb` with `cdb_valid`=1 from edge k+1 for exactly one cycle. There is no same-edge bypass.
- Throughput: one broadcast per cycle.
- Sustained contention alternates A, L, A, L. Worst-case wait for a head entry is 1 cycle.
- A FIFO at full that is granted at edge k asserts ready again in the cycle after edge k.

## Test plan
- Reset: hold `reset`=0 with `alu_valid`=1. Required: `cdb`=0, `cdb_valid`=0, both ready=0, and counts stay 0. Release reset; the first edge accepts the word.
- Single result: push `alu_result`=16'h8015 at edge k. Required: at k+1, `cdb`=16'h8415 (bit 10 forced to 1), `cdb_valid`=1. At k+2, `cdb`=0, `cdb_valid`=0.
- Contention: push A=16'h4003 and L=16'h2407 at the same edge k. Required:
  - k+1: `cdb`=16'h4403.
  - k+2: `cdb`=16'h2007 (bit 10 forced to 0).
  - k+3: idle.
- Back-pressure, DEPTH=2: hold `ldsd_valid`=1 for 4 cycles while A streams continuously. Required: `ldsd_count` reaches 2 and `ldsd_ready` drops; no L word is lost or duplicated; L words appear in push order, alternating with A.
- Wrap-around: push and drain 5 words through A one at a time. Required: all 5 are broadcast in order, and the pointers wrap with no corruption.
- Asynchronous reset with both FIFOs full: assert `reset` between edges. Required: `cdb_valid` falls immediately, counts go to 0, and no queued word is broadcast after release.
